// File: rtl/mtm_alu_serial_rx.sv
// rtl/mtm_alu_serial_rx.sv - serial frame receiver assembling B/A/OP packets with CRC4 check
// Optional idle-gap packet timeout enabled by defining MTM_ALU_RX_TIMEOUT_EN.
module mtm_alu_serial_rx #(
  parameter int OPW         = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sin,
  output logic [8*OPW-1:0]   a,
  output logic [8*OPW-1:0]   b,
  output logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err_valid,
  output logic [3:0]         err_flags
);

  localparam int NB = 2 * OPW;
  localparam int DW = 16 * OPW;
  localparam int CW = $clog2(NB + 2);

  typedef enum logic [1:0] {S_IDLE, S_TYPE, S_PAYLOAD, S_STOP} state_t;

  state_t          state, state_nxt;
  logic [2:0]      bit_cnt;
  logic            is_ctl;
  logic [7:0]      shreg;
  logic [3:0]      crc;
  logic [CW-1:0]   byte_cnt;
  logic [DW-1:0]   data_sr;

  logic            crc_bit, crc_en, fb;
  logic [3:0]      crc_nxt;
  logic            stop_bad, ctl_done, data_done;
  logic            chk_data, chk_crc, chk_op;
  logic            good, ovr, load, timeout;
  logic [3:0]      flags_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!sin) state_nxt = S_TYPE;
      S_TYPE:    state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (bit_cnt == 3'd7) state_nxt = S_STOP;
      S_STOP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // CTL payload feeds a constant 1 in place of its MSB, then OP; its CRC nibble is not hashed.
  always_comb begin
    crc_bit = (is_ctl && bit_cnt == 3'd0) ? 1'b1 : sin;
    crc_en  = (state == S_PAYLOAD) && (!is_ctl || bit_cnt < 3'd4);
    fb      = crc[3] ^ crc_bit;
    crc_nxt = {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
  end

  always_comb begin
    stop_bad  = (state == S_STOP) && !sin;
    ctl_done  = (state == S_STOP) && sin && is_ctl;
    data_done = (state == S_STOP) && sin && !is_ctl;
    chk_data  = byte_cnt != CW'(NB);
    chk_crc   = crc != shreg[3:0];
    chk_op    = shreg[5];
    good      = ctl_done && !chk_data && !chk_crc && !chk_op;
    ovr       = good && out_valid && !out_ready;
    load      = good && !ovr;
    flags_nxt = 4'b0000;
    if (stop_bad || timeout) flags_nxt = 4'b1000;
    else if (ctl_done) begin
      if (chk_data)     flags_nxt = 4'b1000;
      else if (chk_crc) flags_nxt = 4'b0100;
      else if (chk_op)  flags_nxt = 4'b0010;
      else if (ovr)     flags_nxt = 4'b0001;
    end
  end

`ifdef MTM_ALU_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;
  logic          partial;

  assign partial = (byte_cnt != '0) && (byte_cnt <= CW'(NB));
  assign timeout = (state == S_IDLE) && partial && (idle_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || state != S_IDLE || !partial || timeout) idle_cnt <= '0;
    else                                               idle_cnt <= idle_cnt + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      is_ctl    <= 1'b0;
      shreg     <= '0;
      crc       <= '0;
      byte_cnt  <= '0;
      data_sr   <= '0;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      out_valid <= 1'b0;
      err_valid <= 1'b0;
      err_flags <= '0;
    end else begin
      err_valid <= |flags_nxt;
      err_flags <= flags_nxt;
      if (state == S_TYPE) begin
        is_ctl  <= sin;
        bit_cnt <= '0;
      end
      if (state == S_PAYLOAD) begin
        shreg   <= {shreg[6:0], sin};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (crc_en) crc <= crc_nxt;
      if (stop_bad || ctl_done || timeout) begin
        crc      <= '0;
        byte_cnt <= '0;
      end else if (data_done) begin
        if (byte_cnt != CW'(NB + 1)) byte_cnt <= byte_cnt + 1'b1;
        data_sr <= {data_sr[DW-9:0], shreg};
      end
      // A load in the handshake cycle keeps out_valid high with the new result.
      if (load) begin
        b         <= data_sr[DW-1 -: 8*OPW];
        a         <= data_sr[8*OPW-1:0];
        op        <= shreg[6:4];
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_serial_rx.sv
// tb/tb_mtm_alu_serial_rx.sv - randomized bench with packet-level reference model
module tb_mtm_alu_serial_rx;
  localparam int OPW = 4;
  localparam int W   = 8 * OPW;
  localparam int NB  = 2 * OPW;

  logic         clk = 1'b0;
  logic         rst, sin, out_ready;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic         out_valid, err_valid;
  logic [3:0]   err_flags;

  always #5 clk = ~clk;

  mtm_alu_serial_rx #(.OPW(OPW), .TIMEOUT_CYC(1000)) dut (
    .clk(clk), .rst(rst), .sin(sin), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .err_valid(err_valid), .err_flags(err_flags)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_a, exp_b;
  logic [2:0]   exp_op;
  logic         exp_valid, exp_err;
  logic [3:0]   exp_flags;
  logic [7:0]   q[$];
  logic         pend = 1'b0, pend_ctl, pend_stop;
  logic [7:0]   pend_byte;
  logic         chk_en = 1'b0;
  logic         rnd_ready = 1'b0;
  bit           mq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Remainder of M(x)*x^4 divided by x^4+x+1, by long division.
  function automatic logic [3:0] crc_bits(input bit m[$]);
    bit         r[$];
    logic [4:0] g;
    logic [3:0] res;
    g = 5'b10011;
    r = m;
    repeat (4) r.push_back(1'b0);
    for (int i = 0; i < r.size() - 4; i++)
      if (r[i])
        for (int j = 0; j < 5; j++) r[i+j] = r[i+j] ^ g[4-j];
    res = {r[r.size()-4], r[r.size()-3], r[r.size()-2], r[r.size()-1]};
    return res;
  endfunction

  function automatic logic [3:0] pkt_crc(input logic [W-1:0] bv, input logic [W-1:0] av,
                                         input logic [2:0] opv);
    bit m[$];
    for (int i = W - 1; i >= 0; i--) m.push_back(bv[i]);
    for (int i = W - 1; i >= 0; i--) m.push_back(av[i]);
    m.push_back(1'b1);
    for (int i = 2; i >= 0; i--) m.push_back(opv[i]);
    return crc_bits(m);
  endfunction

  // Packet-level reference: consumes completed frames announced by the stimulus.
  initial begin
    logic         hs, ld;
    logic [W-1:0] bv, av;
    logic [2:0]   opv;
    forever begin
      @(posedge clk);
      hs = exp_valid && out_ready;
      ld = 1'b0;
      exp_err = 1'b0;
      exp_flags = 4'b0000;
      if (rst) begin
        exp_a = '0; exp_b = '0; exp_op = '0; exp_valid = 1'b0;
        q.delete();
      end else begin
        if (pend) begin
          if (!pend_stop) begin
            exp_err = 1'b1; exp_flags = 4'b1000;
            q.delete();
          end else if (!pend_ctl) begin
            q.push_back(pend_byte);
          end else begin
            exp_err = 1'b1;
            if (q.size() != NB) exp_flags = 4'b1000;
            else begin
              bv = '0; av = '0;
              for (int i = 0; i < OPW; i++) bv = {bv[W-9:0], q[i]};
              for (int i = OPW; i < NB; i++) av = {av[W-9:0], q[i]};
              opv = pend_byte[6:4];
              if (pkt_crc(bv, av, opv) != pend_byte[3:0]) exp_flags = 4'b0100;
              else if (!(opv == 3'b000 || opv == 3'b001 || opv == 3'b100 || opv == 3'b101))
                exp_flags = 4'b0010;
              else if (exp_valid && !out_ready) exp_flags = 4'b0001;
              else begin
                exp_err = 1'b0; ld = 1'b1;
                exp_a = av; exp_b = bv; exp_op = opv; exp_valid = 1'b1;
              end
            end
            q.delete();
          end
        end
        if (hs && !ld) exp_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", out_valid, exp_valid);
      check("err_valid", err_valid, exp_err);
      if (exp_err) check("err_flags", err_flags, exp_flags);
      if (exp_valid) begin
        check("a", a, exp_a);
        check("b", b, exp_b);
        check("op", op, exp_op);
      end
    end
  end

  task automatic send_bit(input logic v);
    @(negedge clk);
    sin = v;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic ctl, input logic [7:0] byt, input logic stop);
    send_bit(1'b0);
    send_bit(ctl);
    for (int i = 7; i >= 0; i--) send_bit(byt[i]);
    send_bit(stop);
    pend_ctl = ctl; pend_byte = byt; pend_stop = stop; pend = 1'b1;
    send_bit(1'b1);
    pend = 1'b0;
  endtask

  task automatic send_pkt(input logic [W-1:0] bv, input logic [W-1:0] av,
                          input logic [2:0] opv, input logic [3:0] cx);
    for (int i = OPW - 1; i >= 0; i--) send_frame(1'b0, bv[8*i +: 8], 1'b1);
    for (int i = OPW - 1; i >= 0; i--) send_frame(1'b0, av[8*i +: 8], 1'b1);
    send_frame(1'b1, {1'b0, opv, pkt_crc(bv, av, opv) ^ cx}, 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; sin = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic mid_reset(input int k);
    send_bit(1'b0);
    send_bit(1'($urandom_range(0, 1)));
    repeat (k) send_bit(1'($urandom_range(0, 1)));
    pulse_reset();
  endtask

  int           kind, mode, nb;
  logic [W-1:0] rb, ra;
  logic [2:0]   ro;

  initial begin
    rst = 1'b1; sin = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_op", op, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_flags", err_flags, 0);

    mq.delete(); mq.push_back(1'b1);
    check("crc_pin_x4", crc_bits(mq), 4'b0011);
    mq.push_back(1'b0);
    check("crc_pin_x5", crc_bits(mq), 4'b0110);
    mq.push_back(1'b0); mq.push_back(1'b0);
    check("crc_pin_x7", crc_bits(mq), 4'b1011);

    send_pkt(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100, 4'h0);
    check("ones_valid", out_valid, 1);
    check("ones_a", a, 32'hFFFF_FFFF);
    check("ones_b", b, 32'hFFFF_FFFF);
    check("ones_op", op, 3'b100);

    send_frame(1'b0, 8'h55, 1'b1);
    send_frame(1'b0, 8'h0F, 1'b1);
    send_frame(1'b1, 8'h50, 1'b1);
    check("short_err", err_valid, 1);
    check("short_flags", err_flags, 4'b1000);
    check("short_valid", out_valid, 0);

    send_pkt(32'd7, 32'd3, 3'b100, 4'h1);
    check("crc_err_flags", err_flags, 4'b0100);
    send_pkt(32'd7, 32'd3, 3'b100, 4'h0);
    check("crc_ok_valid", out_valid, 1);
    check("crc_ok_a", a, 32'd3);
    check("crc_ok_b", b, 32'd7);

    send_pkt(32'h11, 32'h22, 3'b010, 4'h0);
    check("op_err_flags", err_flags, 4'b0010);
    for (int i = 0; i < 3; i++) send_frame(1'b0, 8'hA0 + 8'(i), 1'b1);
    pulse_reset();
    send_pkt(32'hCAFE_0001, 32'h0BAD_F00D, 3'b001, 4'h0);
    check("after_rst_valid", out_valid, 1);
    check("after_rst_a", a, 32'h0BAD_F00D);
    check("after_rst_err", err_valid, 0);

    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    send_pkt(32'h1234_5678, 32'h9ABC_DEF0, 3'b001, 4'h0);
    check("hold_valid", out_valid, 1);
    send_pkt(32'h0000_0001, 32'h0000_0002, 3'b101, 4'h0);
    check("ovr_flags", err_flags, 4'b0001);
    check("ovr_keep_a", a, 32'h9ABC_DEF0);
    check("ovr_keep_b", b, 32'h1234_5678);
    out_ready = 1'b1;
    @(negedge clk);
    check("ovr_release", out_valid, 0);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      mode = $urandom_range(0, 2);
      rnd_ready = (mode == 2);
      if (mode != 2) out_ready = (mode == 1);
      rb = W'($urandom);
      ra = W'($urandom);
      ro = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) ro[1] = 1'b0;
      case (kind)
        0: send_pkt(rb, ra, ro, 4'($urandom_range(1, 15)));
        1: begin
          nb = $urandom_range(0, NB + 2);
          if (nb == NB) nb = NB + 1;
          repeat (nb) send_frame(1'b0, 8'($urandom), 1'b1);
          send_frame(1'b1, {1'b0, ro, pkt_crc(rb, ra, ro)}, 1'b1);
        end
        2: begin
          repeat ($urandom_range(0, NB)) send_frame(1'b0, 8'($urandom), 1'b1);
          send_frame(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
          send_pkt(rb, ra, ro, 4'h0);
        end
        3: begin
          repeat ($urandom_range(0, NB)) send_frame(1'b0, 8'($urandom), 1'b1);
          mid_reset($urandom_range(0, 8));
        end
        default: send_pkt(rb, ra, ro, 4'h0);
      endcase
    end

    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mtm_alu_serial_rx.md
MTM_ALU_SERIAL_RX -- requirements
Module: mtm_alu_serial_rx

Interface
REQ-001 Parameter OPW, default 4: operand width in bytes (1..8); each operand is 8*OPW bits.
REQ-002 Parameter TIMEOUT_CYC, default 1000: idle-gap limit in clk cycles, used only with REQ-030.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sin  input  1  serial input; idle level 1; one bit per clk.
REQ-006 a  output  8*OPW  operand A of the accepted packet.
REQ-007 b  output  8*OPW  operand B of the accepted packet.
REQ-008 op  output  3  operation code of the accepted packet.
REQ-009 out_valid  output  1  a/b/op valid; held until accepted.
REQ-010 out_ready  input  1  consumer accepts a/b/op when out_valid && out_ready.
REQ-011 err_valid  output  1  one-cycle pulse; err_flags meaningful.
REQ-012 err_flags  output  4  {err_data, err_crc, err_op, err_ovr}.

Function
REQ-013 Frame = 11 bits: start 0, type bit (0 DATA, 1 CTL), 8 payload bits MSB first, stop 1.
REQ-014 Bit FSM states IDLE, TYPE, PAYLOAD(8 bits), STOP; IDLE->TYPE on sin=0; STOP->IDLE unconditionally.
REQ-015 Stop bit sampled as 0: frame discarded, packet state cleared, err_valid pulsed with err_data=1.
REQ-016 Packet order: OPW DATA bytes of B (MSB byte first), OPW DATA bytes of A (MSB byte first), one CTL byte.
REQ-017 CTL byte = {1'b0, OP[2:0], CRC[3:0]}.
REQ-018 CRC: polynomial x^4+x+1, init 4'b0000, over bit vector {B, A, 1'b1, OP}, leftmost bit first; computed serially while payload bits arrive.
REQ-019 DATA byte counter saturates at 2*OPW+1; any count other than 2*OPW at CTL reception = err_data.
REQ-020 On CTL, checks in priority order: err_data, then err_crc (CRC mismatch), then err_op (OP not in {000,001,100,101}); exactly one flag set.
REQ-021 Packet with no error: a/b/op loaded and out_valid set in the cycle after the CTL stop bit is sampled.
REQ-022 Any error: err_valid pulses one cycle after the CTL stop bit; a/b/op/out_valid unchanged; not subject to out_ready.
REQ-023 After any CTL (good or bad), byte counter and CRC cleared; next frame starts a new packet.
REQ-024 out_valid cleared in the cycle after out_valid && out_ready.
REQ-025 Good packet completes while out_valid=1 and out_ready=0: new packet dropped, err_valid with err_ovr=1; held output unchanged.
REQ-026 Good packet completes in the same cycle as handshake: new result loaded, out_valid stays 1, no overrun.
REQ-027 Reception continues regardless of out_valid; no backpressure on sin.

Reset
REQ-028 rst=1: FSM to IDLE, byte counter and CRC 0, a=0, b=0, op=0, out_valid=0, err_valid=0, err_flags=0.
REQ-029 rst asserted mid-frame or mid-packet abandons it without any error pulse; first frame after release is a new packet's first byte.

Configuration
REQ-030 Macro MTM_ALU_RX_TIMEOUT_EN defined: with 1..2*OPW DATA bytes held and bit FSM in IDLE for TIMEOUT_CYC consecutive cycles, packet dropped, counter/CRC cleared, err_valid with err_data=1.
REQ-031 Macro MTM_ALU_RX_TIMEOUT_EN undefined: no timeout logic; partial packets held indefinitely; TIMEOUT_CYC unused.

Verification
REQ-032 OPW=4, B=A=0xFFFFFFFF, OP=100, correct CRC, out_ready=1 -> out_valid 1 cycle after CTL stop, a=b=0xFFFFFFFF, op=100.
REQ-033 OPW=4, DATA 0x55, DATA 0x0F, CTL 0x50 -> err_valid, err_flags=4'b1000, out_valid unchanged.
REQ-034 OPW=4, A=3, B=7, OP=100, CTL CRC field XOR 4'h1 -> err_flags=4'b0100; then same packet with correct CRC -> out_valid, a=3, b=7.
REQ-035 OPW=2, two good packets back-to-back with out_ready=0 -> first held; second gives err_flags=4'b0001; out_ready=1 then clears out_valid next cycle.
REQ-036 OPW=4, OP=010 with correct CRC -> err_flags=4'b0010; rst pulsed after 3 DATA bytes, then full good packet -> accepted with no error pulse.
REQ-037 MTM_ALU_RX_TIMEOUT_EN, TIMEOUT_CYC=50: 3 DATA bytes then 50 idle cycles -> err_flags=4'b1000; following good packet accepted.
